// File: rtl/req_router.sv
// Single-outstanding request router: steers each upstream burst to the memory
// port (m0) or the peripheral port (m1) by the top address nibble.
module req_router #(
  parameter logic [3:0] PERIPH_SEL = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  // upstream request
  input  logic        s_req_valid,
  output logic        s_req_ready,
  input  logic [2:0]  s_req_len,
  input  logic [3:0]  s_req_mask,
  input  logic [31:0] s_req_addr,
  input  logic        s_req_we,
  input  logic        s_write_valid,
  input  logic [31:0] s_write_data,
  output logic        s_read_valid,
  input  logic        s_read_ack,
  output logic [31:0] s_read_data,
  // memory port
  output logic        m0_req_valid,
  input  logic        m0_req_ready,
  output logic [2:0]  m0_req_len,
  output logic [3:0]  m0_req_mask,
  output logic [31:0] m0_req_addr,
  output logic        m0_req_we,
  output logic        m0_write_valid,
  output logic [31:0] m0_write_data,
  input  logic        m0_read_valid,
  output logic        m0_read_ack,
  input  logic [31:0] m0_read_data,
  // peripheral port
  output logic        m1_req_valid,
  input  logic        m1_req_ready,
  output logic [2:0]  m1_req_len,
  output logic [3:0]  m1_req_mask,
  output logic [31:0] m1_req_addr,
  output logic        m1_req_we,
  output logic        m1_write_valid,
  output logic [31:0] m1_write_data,
  input  logic        m1_read_valid,
  output logic        m1_read_ack,
  input  logic [31:0] m1_read_data
);

  typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

  state_t      state_reg;
  logic [2:0]  len_reg;
  logic [3:0]  mask_reg;
  logic [31:0] addr_reg;
  logic        we_reg;
  logic        sel_reg;
  logic [3:0]  beats_reg;
  logic [1:0]  req_valid_reg;

  logic [31:0] fifo_mem [0:7];
  logic [2:0]  wr_ptr_reg;
  logic [2:0]  rd_ptr_reg;
  logic [3:0]  count_reg;

  logic        sel_ready;
  logic        sel_read_valid;
  logic [31:0] sel_read_data;
  logic        fifo_push;
  logic        fifo_pop;
  logic        read_beat;
  logic [31:0] fifo_head;

  assign sel_ready      = sel_reg ? m1_req_ready  : m0_req_ready;
  assign sel_read_valid = sel_reg ? m1_read_valid : m0_read_valid;
  assign sel_read_data  = sel_reg ? m1_read_data  : m0_read_data;
  // Write beats are only meaningful once a request is in flight.
  assign fifo_push      = s_write_valid && (state_reg != IDLE);
  assign fifo_pop       = (state_reg == WDATA) && (count_reg != 4'd0);
  assign read_beat      = (state_reg == RDATA) && sel_read_valid && s_read_ack;
  assign fifo_head      = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_reg] <= s_write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= 3'd0;
      rd_ptr_reg <= 3'd0;
      count_reg  <= 4'd0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 3'd1;
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 3'd1;
      case ({fifo_push, fifo_pop})
        2'b10:   count_reg <= count_reg + 4'd1;
        2'b01:   count_reg <= count_reg - 4'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      len_reg       <= 3'd0;
      mask_reg      <= 4'd0;
      addr_reg      <= 32'd0;
      we_reg        <= 1'b0;
      sel_reg       <= 1'b0;
      beats_reg     <= 4'd0;
      req_valid_reg <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (s_req_valid) begin
            len_reg       <= s_req_len;
            mask_reg      <= s_req_mask;
            addr_reg      <= s_req_addr;
            we_reg        <= s_req_we;
            sel_reg       <= (s_req_addr[31:28] == PERIPH_SEL);
            beats_reg     <= {1'b0, s_req_len} + 4'd1;
            req_valid_reg <= (s_req_addr[31:28] == PERIPH_SEL) ? 2'b10 : 2'b01;
            state_reg     <= REQ;
          end
        end
        REQ: begin
          if (sel_ready) begin
            req_valid_reg <= 2'b00;
            state_reg     <= we_reg ? WDATA : RDATA;
          end
        end
        WDATA: begin
          if (fifo_pop) begin
            beats_reg <= beats_reg - 4'd1;
            if (beats_reg == 4'd1) state_reg <= IDLE;
          end
        end
        RDATA: begin
          if (read_beat) begin
            beats_reg <= beats_reg - 4'd1;
            if (beats_reg == 4'd1) state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s_req_ready = (state_reg == IDLE);

  // Request fields are shown only on the port that owns the request.
  assign m0_req_valid = req_valid_reg[0];
  assign m0_req_len   = sel_reg ? 3'd0  : len_reg;
  assign m0_req_mask  = sel_reg ? 4'd0  : mask_reg;
  assign m0_req_addr  = sel_reg ? 32'd0 : addr_reg;
  assign m0_req_we    = sel_reg ? 1'b0  : we_reg;
  assign m1_req_valid = req_valid_reg[1];
  assign m1_req_len   = sel_reg ? len_reg  : 3'd0;
  assign m1_req_mask  = sel_reg ? mask_reg : 4'd0;
  assign m1_req_addr  = sel_reg ? addr_reg : 32'd0;
  assign m1_req_we    = sel_reg ? we_reg   : 1'b0;

  assign m0_write_valid = fifo_pop && !sel_reg;
  assign m0_write_data  = (fifo_pop && !sel_reg) ? fifo_head : 32'd0;
  assign m1_write_valid = fifo_pop && sel_reg;
  assign m1_write_data  = (fifo_pop && sel_reg) ? fifo_head : 32'd0;

  assign s_read_valid = (state_reg == RDATA) && sel_read_valid;
  assign s_read_data  = (state_reg == RDATA) ? sel_read_data : 32'd0;
  assign m0_read_ack  = (state_reg == RDATA) && !sel_reg && s_read_ack;
  assign m1_read_ack  = (state_reg == RDATA) && sel_reg && s_read_ack;

endmodule

// File: tb/tb_req_router.sv
// Directed bench for req_router: write/read routing, backpressure, FIFO wrap,
// back-to-back requests and asynchronous reset mid-burst.
module tb_req_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_req_valid;
  logic        s_req_ready;
  logic [2:0]  s_req_len;
  logic [3:0]  s_req_mask;
  logic [31:0] s_req_addr;
  logic        s_req_we;
  logic        s_write_valid;
  logic [31:0] s_write_data;
  logic        s_read_valid;
  logic        s_read_ack;
  logic [31:0] s_read_data;
  logic        m0_req_valid, m0_req_ready, m0_req_we, m0_write_valid, m0_read_valid, m0_read_ack;
  logic [2:0]  m0_req_len;
  logic [3:0]  m0_req_mask;
  logic [31:0] m0_req_addr, m0_write_data, m0_read_data;
  logic        m1_req_valid, m1_req_ready, m1_req_we, m1_write_valid, m1_read_valid, m1_read_ack;
  logic [2:0]  m1_req_len;
  logic [3:0]  m1_req_mask;
  logic [31:0] m1_req_addr, m1_write_data, m1_read_data;

  int checks = 0;
  int failures = 0;

  req_router #(.PERIPH_SEL(4'hF)) dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_len(s_req_len),
    .s_req_mask(s_req_mask), .s_req_addr(s_req_addr), .s_req_we(s_req_we),
    .s_write_valid(s_write_valid), .s_write_data(s_write_data),
    .s_read_valid(s_read_valid), .s_read_ack(s_read_ack), .s_read_data(s_read_data),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_len(m0_req_len),
    .m0_req_mask(m0_req_mask), .m0_req_addr(m0_req_addr), .m0_req_we(m0_req_we),
    .m0_write_valid(m0_write_valid), .m0_write_data(m0_write_data),
    .m0_read_valid(m0_read_valid), .m0_read_ack(m0_read_ack), .m0_read_data(m0_read_data),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_len(m1_req_len),
    .m1_req_mask(m1_req_mask), .m1_req_addr(m1_req_addr), .m1_req_we(m1_req_we),
    .m1_write_valid(m1_write_valid), .m1_write_data(m1_write_data),
    .m1_read_valid(m1_read_valid), .m1_read_ack(m1_read_ack), .m1_read_data(m1_read_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [2:0] len,
                       input logic [3:0] mask, input logic we);
    s_req_valid = 1'b1;
    s_req_addr  = addr;
    s_req_len   = len;
    s_req_mask  = mask;
    s_req_we    = we;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_req_valid = 0; s_req_len = 0; s_req_mask = 0; s_req_addr = 0; s_req_we = 0;
    s_write_valid = 0; s_write_data = 0; s_read_ack = 0;
    m0_req_ready = 0; m0_read_valid = 0; m0_read_data = 0;
    m1_req_ready = 0; m1_read_valid = 0; m1_read_data = 0;
    #2;
    checks++; if (m0_req_valid !== 1'b0 || m1_req_valid !== 1'b0) begin failures++;
      $display("FAIL reset_req_valid got=%b%b exp=00", m1_req_valid, m0_req_valid); end
    checks++; if (s_read_valid !== 1'b0 || s_read_data !== 32'd0) begin failures++;
      $display("FAIL reset_read got=%b/%h exp=0/0", s_read_valid, s_read_data); end
    checks++; if (m0_write_valid !== 1'b0 || m1_write_valid !== 1'b0) begin failures++;
      $display("FAIL reset_write_valid got=%b%b exp=00", m1_write_valid, m0_write_valid); end
    #10;
    rst = 1'b1;
    tick();
    checks++; if (s_req_ready !== 1'b1) begin failures++;
      $display("FAIL reset_ready got=%b exp=1", s_req_ready); end
    $display("reset: released");
  endtask

  task automatic test_write_mem();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h33; exp_data[3] = 32'h44;
    issue(32'h0000_1000, 3'd3, 4'hF, 1'b1);
    #1;
    checks++; if (s_req_ready !== 1'b1) begin failures++;
      $display("FAIL wr_ready_idle got=%b exp=1", s_req_ready); end
    tick();
    s_req_valid = 1'b0;
    checks++; if (m0_req_valid !== 1'b1 || m1_req_valid !== 1'b0) begin failures++;
      $display("FAIL wr_req_valid got=m0:%b m1:%b exp=m0:1 m1:0", m0_req_valid, m1_req_valid); end
    checks++; if (m0_req_addr !== 32'h0000_1000 || m0_req_len !== 3'd3 || m0_req_we !== 1'b1) begin
      failures++;
      $display("FAIL wr_req_fields got=%h/%0d/%b exp=00001000/3/1", m0_req_addr, m0_req_len, m0_req_we); end
    checks++; if (s_req_ready !== 1'b0) begin failures++;
      $display("FAIL wr_ready_req got=%b exp=0", s_req_ready); end
    for (int i = 0; i < 4; i++) begin
      s_write_valid = 1'b1;
      s_write_data  = exp_data[i];
      m0_req_ready  = (i == 3);
      #1;
      checks++; if (m0_req_valid !== 1'b1) begin failures++;
        $display("FAIL wr_req_hold cycle=%0d got=%b exp=1", i, m0_req_valid); end
      tick();
    end
    s_write_valid = 1'b0;
    m0_req_ready  = 1'b0;
    #1;
    checks++; if (m0_req_valid !== 1'b0) begin failures++;
      $display("FAIL wr_req_drop got=%b exp=0", m0_req_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (m0_write_valid !== 1'b1 || m0_write_data !== exp_data[i]) begin failures++;
        $display("FAIL wr_beat%0d got=%b/%h exp=1/%h", i, m0_write_valid, m0_write_data, exp_data[i]); end
      checks++; if (m1_write_valid !== 1'b0) begin failures++;
        $display("FAIL wr_m1_silent beat=%0d got=%b exp=0", i, m1_write_valid); end
      tick();
    end
    checks++; if (m0_write_valid !== 1'b0 || s_req_ready !== 1'b1) begin failures++;
      $display("FAIL wr_done got=wv:%b rdy:%b exp=wv:0 rdy:1", m0_write_valid, s_req_ready); end
    $display("write m0 addr=00001000 len=3 done");
  endtask

  task automatic test_read_periph();
    issue(32'hF040_0000, 3'd0, 4'hF, 1'b0);
    tick();
    s_req_valid = 1'b0;
    #1;
    checks++; if (m1_req_valid !== 1'b1 || m0_req_valid !== 1'b0) begin failures++;
      $display("FAIL rp_req_valid got=m0:%b m1:%b exp=m0:0 m1:1", m0_req_valid, m1_req_valid); end
    checks++; if (m1_req_addr !== 32'hF040_0000) begin failures++;
      $display("FAIL rp_req_addr got=%h exp=f0400000", m1_req_addr); end
    m1_req_ready = 1'b1;
    tick();
    m1_req_ready  = 1'b0;
    m1_read_valid = 1'b1;
    m1_read_data  = 32'hDEAD_BEEF;
    #1;
    checks++; if (m1_req_valid !== 1'b0) begin failures++;
      $display("FAIL rp_req_drop got=%b exp=0", m1_req_valid); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (s_read_valid !== 1'b1 || s_read_data !== 32'hDEAD_BEEF || m1_read_ack !== 1'b0) begin
        failures++;
        $display("FAIL rp_wait%0d got=%b/%h ack=%b exp=1/deadbeef ack=0", i, s_read_valid, s_read_data, m1_read_ack); end
      tick();
    end
    s_read_ack = 1'b1;
    #1;
    checks++; if (m1_read_ack !== 1'b1 || m0_read_ack !== 1'b0) begin failures++;
      $display("FAIL rp_ack got=m0:%b m1:%b exp=m0:0 m1:1", m0_read_ack, m1_read_ack); end
    tick();
    s_read_ack = 1'b0;
    #1;
    checks++; if (s_req_ready !== 1'b1 || s_read_valid !== 1'b0 || s_read_data !== 32'd0) begin failures++;
      $display("FAIL rp_idle got=rdy:%b rv:%b rd:%h exp=rdy:1 rv:0 rd:0", s_req_ready, s_read_valid, s_read_data); end
    m1_read_valid = 1'b0;
    m1_read_data  = 32'd0;
    $display("read m1 addr=f0400000 len=0 done");
  endtask

  task automatic test_read_burst();
    m1_read_valid = 1'b1;
    m1_read_data  = 32'hBAD0_BAD0;
    issue(32'h0000_2000, 3'd7, 4'hF, 1'b0);
    tick();
    s_req_valid  = 1'b0;
    m0_req_ready = 1'b1;
    tick();
    m0_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        m0_read_valid = 1'b0;
        s_read_ack    = 1'b1;
        #1;
        checks++; if (s_read_valid !== 1'b0 || m1_read_ack !== 1'b0) begin failures++;
          $display("FAIL rb_bubble got=rv:%b m1ack:%b exp=0/0", s_read_valid, m1_read_ack); end
        tick();
      end
      m0_read_valid = 1'b1;
      m0_read_data  = 32'hA000_0000 + 32'(i);
      s_read_ack    = 1'b1;
      #1;
      checks++; if (s_read_valid !== 1'b1 || s_read_data !== 32'hA000_0000 + 32'(i)) begin failures++;
        $display("FAIL rb_beat%0d got=%b/%h exp=1/%h", i, s_read_valid, s_read_data, 32'hA000_0000 + 32'(i)); end
      checks++; if (m1_read_ack !== 1'b0 || m0_read_ack !== 1'b1) begin failures++;
        $display("FAIL rb_ack%0d got=m0:%b m1:%b exp=m0:1 m1:0", i, m0_read_ack, m1_read_ack); end
      tick();
    end
    m0_read_valid = 1'b0;
    s_read_ack    = 1'b0;
    #1;
    checks++; if (s_req_ready !== 1'b1 || s_read_valid !== 1'b0) begin failures++;
      $display("FAIL rb_done got=rdy:%b rv:%b exp=rdy:1 rv:0", s_req_ready, s_read_valid); end
    m1_read_valid = 1'b0;
    m1_read_data  = 32'd0;
    $display("read m0 addr=00002000 len=7 done");
  endtask

  task automatic test_write_wrap();
    // A stray beat in IDLE must be dropped, then an 8-beat burst wraps the FIFO pointers.
    s_write_valid = 1'b1;
    s_write_data  = 32'h0000_0BAD;
    tick();
    s_write_valid = 1'b0;
    issue(32'hF000_0010, 3'd7, 4'h3, 1'b1);
    tick();
    s_req_valid = 1'b0;
    #1;
    checks++; if (m1_req_mask !== 4'h3 || m0_req_mask !== 4'h0 || m1_req_len !== 3'd7) begin failures++;
      $display("FAIL ww_fields got=m1mask:%h m0mask:%h len:%0d exp=3/0/7", m1_req_mask, m0_req_mask, m1_req_len); end
    for (int i = 0; i < 8; i++) begin
      s_write_valid = 1'b1;
      s_write_data  = 32'hC0DE_0000 + 32'(i);
      m1_req_ready  = (i == 7);
      tick();
    end
    s_write_valid = 1'b0;
    m1_req_ready  = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (m1_write_valid !== 1'b1 || m1_write_data !== 32'hC0DE_0000 + 32'(i) || m0_write_valid !== 1'b0) begin
        failures++;
        $display("FAIL ww_beat%0d got=%b/%h m0wv:%b exp=1/%h m0wv:0", i, m1_write_valid, m1_write_data,
                 m0_write_valid, 32'hC0DE_0000 + 32'(i)); end
      tick();
    end
    checks++; if (m1_write_valid !== 1'b0 || s_req_ready !== 1'b1) begin failures++;
      $display("FAIL ww_done got=wv:%b rdy:%b exp=0/1", m1_write_valid, s_req_ready); end
    $display("write m1 addr=f0000010 len=7 done");
  endtask

  task automatic test_back_to_back();
    issue(32'h0000_3000, 3'd1, 4'hF, 1'b1);
    tick();
    issue(32'h0000_4000, 3'd0, 4'hF, 1'b0);
    s_write_valid = 1'b1;
    s_write_data  = 32'hA1;
    m0_req_ready  = 1'b1;
    #1;
    checks++; if (s_req_ready !== 1'b0) begin failures++;
      $display("FAIL b2b_ready_req got=%b exp=0", s_req_ready); end
    tick();
    m0_req_ready = 1'b0;
    s_write_data = 32'hA2;
    #1;
    checks++; if (s_req_ready !== 1'b0 || m0_write_valid !== 1'b1 || m0_write_data !== 32'hA1) begin failures++;
      $display("FAIL b2b_beat0 got=rdy:%b %b/%h exp=rdy:0 1/a1", s_req_ready, m0_write_valid, m0_write_data); end
    tick();
    s_write_valid = 1'b0;
    #1;
    checks++; if (s_req_ready !== 1'b0 || m0_write_valid !== 1'b1 || m0_write_data !== 32'hA2) begin failures++;
      $display("FAIL b2b_beat1 got=rdy:%b %b/%h exp=rdy:0 1/a2", s_req_ready, m0_write_valid, m0_write_data); end
    tick();
    checks++; if (s_req_ready !== 1'b1 || m0_write_valid !== 1'b0) begin failures++;
      $display("FAIL b2b_idle got=rdy:%b wv:%b exp=1/0", s_req_ready, m0_write_valid); end
    tick();
    s_req_valid = 1'b0;
    #1;
    checks++; if (m0_req_valid !== 1'b1 || m0_req_we !== 1'b0 || m0_req_addr !== 32'h0000_4000) begin failures++;
      $display("FAIL b2b_second got=%b we:%b %h exp=1 we:0 00004000", m0_req_valid, m0_req_we, m0_req_addr); end
    m0_req_ready = 1'b1;
    tick();
    m0_req_ready  = 1'b0;
    m0_read_valid = 1'b1;
    m0_read_data  = 32'h55;
    s_read_ack    = 1'b1;
    #1;
    checks++; if (s_read_valid !== 1'b1 || s_read_data !== 32'h55) begin failures++;
      $display("FAIL b2b_read got=%b/%h exp=1/55", s_read_valid, s_read_data); end
    tick();
    m0_read_valid = 1'b0;
    s_read_ack    = 1'b0;
    #1;
    checks++; if (s_req_ready !== 1'b1) begin failures++;
      $display("FAIL b2b_done got=%b exp=1", s_req_ready); end
    $display("back-to-back write 00003000 then read 00004000 done");
  endtask

  task automatic test_reset_mid_read();
    issue(32'h0000_5000, 3'd7, 4'hF, 1'b0);
    tick();
    s_req_valid  = 1'b0;
    m0_req_ready = 1'b1;
    tick();
    m0_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m0_read_valid = 1'b1;
      m0_read_data  = 32'h5000_0000 + 32'(i);
      s_read_ack    = 1'b1;
      tick();
    end
    s_read_ack   = 1'b0;
    m0_read_data = 32'h5000_0002;
    #1;
    checks++; if (s_read_valid !== 1'b1 || s_read_data !== 32'h5000_0002) begin failures++;
      $display("FAIL rr_beat3 got=%b/%h exp=1/50000002", s_read_valid, s_read_data); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (s_read_valid !== 1'b0 || s_read_data !== 32'd0 || m0_read_ack !== 1'b0) begin failures++;
      $display("FAIL rr_async got=rv:%b rd:%h ack:%b exp=0/0/0", s_read_valid, s_read_data, m0_read_ack); end
    checks++; if (m0_req_valid !== 1'b0 || m0_req_addr !== 32'd0 || s_req_ready !== 1'b1) begin failures++;
      $display("FAIL rr_state got=rv:%b addr:%h rdy:%b exp=0/0/1", m0_req_valid, m0_req_addr, s_req_ready); end
    m0_read_valid = 1'b0;
    m0_read_data  = 32'd0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (s_req_ready !== 1'b1) begin failures++;
      $display("FAIL rr_ready_after got=%b exp=1", s_req_ready); end
    issue(32'h0000_0000, 3'd0, 4'hF, 1'b0);
    tick();
    s_req_valid = 1'b0;
    #1;
    checks++; if (m0_req_valid !== 1'b1 || m0_req_len !== 3'd0 || m1_req_valid !== 1'b0) begin failures++;
      $display("FAIL rr_new_req got=m0:%b len:%0d m1:%b exp=1/0/0", m0_req_valid, m0_req_len, m1_req_valid); end
    m0_req_ready = 1'b1;
    tick();
    m0_req_ready  = 1'b0;
    m0_read_valid = 1'b1;
    m0_read_data  = 32'h600D_F00D;
    s_read_ack    = 1'b1;
    #1;
    checks++; if (s_read_valid !== 1'b1 || s_read_data !== 32'h600D_F00D) begin failures++;
      $display("FAIL rr_new_data got=%b/%h exp=1/600df00d", s_read_valid, s_read_data); end
    tick();
    m0_read_valid = 1'b0;
    s_read_ack    = 1'b0;
    #1;
    checks++; if (s_req_ready !== 1'b1) begin failures++;
      $display("FAIL rr_new_done got=%b exp=1", s_req_ready); end
    $display("reset mid-read then read 00000000 len=0 done");
  endtask

  initial begin
    test_reset();
    test_write_mem();
    test_read_periph();
    test_read_burst();
    test_write_wrap();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
